// File: rtl/ep0_control_seq_if.sv
// EP0 control-sequencer bus: tokens, rx status, setup fields in; buffer control, tx and handshake requests out.
interface ep0_control_seq_if #(
  parameter int unsigned LEN_W = 7
);
  logic             setup_token;
  logic             in_token;
  logic             out_token;
  logic             rx_byte_valid;
  logic             rx_pkt_end;
  logic             rx_crc_ok;
  logic             host_ack;
  logic             req_dir;
  logic [1:0]       req_type;
  logic [4:0]       req_recipient;
  logic [7:0]       bRequest;
  logic [15:0]      wValue;
  logic [15:0]      wLength;
  logic [15:0]      desc_len;
  logic             sbuf_en;
  logic             sbuf_clear;
  logic             tx_req;
  logic [LEN_W-1:0] tx_len;
  logic [15:0]      tx_offset;
  logic             tx_data1;
  logic             hs_ack;
  logic             hs_stall;
  logic             hs_nak;
  logic [6:0]       dev_addr;
  logic [7:0]       config_value;

  modport master (
    input  setup_token, in_token, out_token, rx_byte_valid, rx_pkt_end, rx_crc_ok, host_ack,
    input  req_dir, req_type, req_recipient, bRequest, wValue, wLength, desc_len,
    output sbuf_en, sbuf_clear, tx_req, tx_len, tx_offset, tx_data1,
    output hs_ack, hs_stall, hs_nak, dev_addr, config_value
  );

  modport slave (
    output setup_token, in_token, out_token, rx_byte_valid, rx_pkt_end, rx_crc_ok, host_ack,
    output req_dir, req_type, req_recipient, bRequest, wValue, wLength, desc_len,
    input  sbuf_en, sbuf_clear, tx_req, tx_len, tx_offset, tx_data1,
    input  hs_ack, hs_stall, hs_nak, dev_addr, config_value
  );
endinterface

// File: rtl/ep0_control_seq.sv
// Endpoint-0 control-transfer sequencer: setup capture, data/status stages, address and configuration.
// Macro USB_EP0_STALL_EN: when undefined, unsupported no-data OUT requests complete with a ZLP instead of STALL.
module ep0_control_seq #(
  parameter int unsigned MAX_PKT = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic                clk,
  input  logic                reset,
  ep0_control_seq_if.master   bus
);
  localparam logic [15:0]      MaxPkt16  = 16'(MAX_PKT);
  localparam logic [LEN_W-1:0] MaxPktLen = LEN_W'(MAX_PKT);
  localparam logic [7:0]       ReqGetDesc = 8'd6;
  localparam logic [7:0]       ReqSetAddr = 8'd5;
  localparam logic [7:0]       ReqSetCfg  = 8'd9;

`ifdef USB_EP0_STALL_EN
  localparam bit StallAll = 1'b1;
`else
  localparam bit StallAll = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP_RX, DECODE, DATA_IN, DATA_WAIT, STATUS_OUT, STATUS_IN, STALL
  } state_t;

  state_t      state;
  logic [3:0]  byteCnt;
  logic [15:0] xferLen;
  logic [15:0] remaining;
  logic [15:0] offset;
  logic        toggle;
  logic        pendAddr;
  logic        pendCfg;

  logic        isStd;
  logic        isGetDesc;
  logic        isSetAddr;
  logic        isSetCfg;
  logic        isNoDataOut;
  logic [15:0] xferCalc;
  logic [LEN_W-1:0] nextLen;
  logic        unusedBits;

  assign isStd       = (bus.req_type == 2'd0) && (bus.req_recipient == 5'd0);
  assign isNoDataOut = !bus.req_dir && (bus.wLength == 16'd0);
  assign isGetDesc   = isStd && (bus.bRequest == ReqGetDesc) && bus.req_dir && (bus.desc_len != 16'd0);
  assign isSetAddr   = isStd && (bus.bRequest == ReqSetAddr) && isNoDataOut;
  assign isSetCfg    = isStd && (bus.bRequest == ReqSetCfg) && isNoDataOut;
  assign xferCalc    = (bus.wLength < bus.desc_len) ? bus.wLength : bus.desc_len;
  assign nextLen     = (remaining < MaxPkt16) ? LEN_W'(remaining) : MaxPktLen;
  assign unusedBits  = ^bus.wValue[15:8];

  // Sequencer: all outputs registered; handshake/tx/clear outputs are single-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      byteCnt          <= 4'd0;
      xferLen          <= 16'd0;
      remaining        <= 16'd0;
      offset           <= 16'd0;
      toggle           <= 1'b0;
      pendAddr         <= 1'b0;
      pendCfg          <= 1'b0;
      bus.sbuf_en      <= 1'b0;
      bus.sbuf_clear   <= 1'b0;
      bus.tx_req       <= 1'b0;
      bus.tx_len       <= '0;
      bus.tx_offset    <= 16'd0;
      bus.tx_data1     <= 1'b0;
      bus.hs_ack       <= 1'b0;
      bus.hs_stall     <= 1'b0;
      bus.hs_nak       <= 1'b0;
      bus.dev_addr     <= 7'd0;
      bus.config_value <= 8'd0;
    end else begin
      bus.sbuf_clear <= 1'b0;
      bus.tx_req     <= 1'b0;
      bus.hs_ack     <= 1'b0;
      bus.hs_stall   <= 1'b0;
      bus.hs_nak     <= 1'b0;

      if (bus.setup_token) begin
        state          <= SETUP_RX;
        bus.sbuf_clear <= 1'b1;
        bus.sbuf_en    <= 1'b1;
        byteCnt        <= 4'd0;
        pendAddr       <= 1'b0;
        pendCfg        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_token || bus.out_token) bus.hs_nak <= 1'b1;
          end
          SETUP_RX: begin
            if (bus.rx_byte_valid && byteCnt != 4'd9) byteCnt <= byteCnt + 4'd1;
            if (bus.rx_pkt_end) begin
              bus.sbuf_en <= 1'b0;
              if (bus.rx_crc_ok && byteCnt == 4'd8) begin
                bus.hs_ack <= 1'b1;
                state      <= DECODE;
              end else begin
                state <= IDLE;
              end
            end
          end
          DECODE: begin
            if (isGetDesc) begin
              xferLen   <= xferCalc;
              remaining <= xferCalc;
              offset    <= 16'd0;
              toggle    <= 1'b1;
              state     <= (bus.wLength == 16'd0) ? STATUS_IN : DATA_IN;
            end else if (isSetAddr) begin
              pendAddr <= 1'b1;
              state    <= STATUS_IN;
            end else if (isSetCfg) begin
              pendCfg <= 1'b1;
              state   <= STATUS_IN;
            end else if (!StallAll && isNoDataOut) begin
              state <= STATUS_IN;
            end else begin
              state <= STALL;
            end
          end
          DATA_IN: begin
            if (bus.out_token) begin
              state <= STATUS_OUT;
            end else if (bus.in_token) begin
              bus.tx_req    <= 1'b1;
              bus.tx_len    <= nextLen;
              bus.tx_offset <= offset;
              bus.tx_data1  <= toggle;
              state         <= DATA_WAIT;
            end
          end
          DATA_WAIT: begin
            if (bus.host_ack) begin
              remaining <= remaining - 16'(bus.tx_len);
              offset    <= offset + 16'(bus.tx_len);
              toggle    <= ~toggle;
              // Short packet, or exact-length transfer fully sent, ends the data stage
              if (bus.tx_len < MaxPktLen ||
                  (remaining == 16'(bus.tx_len) && xferLen == bus.wLength))
                state <= STATUS_OUT;
              else
                state <= DATA_IN;
            end else if (bus.out_token) begin
              state <= STATUS_OUT;
            end else if (bus.in_token) begin
              bus.tx_req <= 1'b1;
            end
          end
          STATUS_OUT: begin
            if (bus.rx_pkt_end && bus.rx_crc_ok) begin
              bus.hs_ack <= 1'b1;
              state      <= IDLE;
            end else if (bus.in_token) begin
              bus.hs_stall <= 1'b1;
            end
          end
          STATUS_IN: begin
            if (bus.host_ack) begin
              if (pendAddr) bus.dev_addr <= bus.wValue[6:0];
              if (pendCfg) bus.config_value <= bus.wValue[7:0];
              pendAddr <= 1'b0;
              pendCfg  <= 1'b0;
              state    <= IDLE;
            end else if (bus.in_token) begin
              bus.tx_req   <= 1'b1;
              bus.tx_len   <= '0;
              bus.tx_data1 <= 1'b1;
            end
          end
          STALL: begin
            if (bus.in_token || bus.out_token) bus.hs_stall <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ep0_control_seq.sv
// Directed self-checking bench for ep0_control_seq; honours USB_EP0_STALL_EN for the unsupported-request case.
module tb_ep0_control_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic ackSeen;

  ep0_control_seq_if #(.LEN_W(7)) bus ();

  ep0_control_seq #(.MAX_PKT(64), .LEN_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic dir, input logic [1:0] typ, input logic [7:0] req,
                         input logic [15:0] val, input logic [15:0] len, input logic [15:0] dlen);
    bus.req_dir       = dir;
    bus.req_type      = typ;
    bus.req_recipient = 5'd0;
    bus.bRequest      = req;
    bus.wValue        = val;
    bus.wLength       = len;
    bus.desc_len      = dlen;
  endtask

  // SETUP token, nbytes payload strobes, packet end; returns the handshake seen after packet end
  task automatic setup_pkt(input int nbytes, input logic crc, output logic ack);
    bus.setup_token = 1'b1;
    tick();
    bus.setup_token = 1'b0;
    chk("sbuf_clear", 32'(bus.sbuf_clear), 32'd1);
    chk("sbuf_en", 32'(bus.sbuf_en), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      bus.rx_byte_valid = 1'b1;
      tick();
      bus.rx_byte_valid = 1'b0;
    end
    bus.rx_pkt_end = 1'b1;
    bus.rx_crc_ok  = crc;
    tick();
    bus.rx_pkt_end = 1'b0;
    bus.rx_crc_ok  = 1'b0;
    ack = bus.hs_ack;
    tick();
  endtask

  task automatic in_tok();
    bus.in_token = 1'b1;
    tick();
    bus.in_token = 1'b0;
  endtask

  task automatic out_tok();
    bus.out_token = 1'b1;
    tick();
    bus.out_token = 1'b0;
  endtask

  task automatic ack_tok();
    bus.host_ack = 1'b1;
    tick();
    bus.host_ack = 1'b0;
  endtask

  task automatic pkt_end(input logic crc);
    bus.rx_pkt_end = 1'b1;
    bus.rx_crc_ok  = crc;
    tick();
    bus.rx_pkt_end = 1'b0;
    bus.rx_crc_ok  = 1'b0;
  endtask

  task automatic chk_tx(input string tag, input int len, input int off, input logic d1);
    chk({tag, ".tx_req"}, 32'(bus.tx_req), 32'd1);
    chk({tag, ".tx_len"}, 32'(bus.tx_len), 32'(len));
    chk({tag, ".tx_offset"}, 32'(bus.tx_offset), 32'(off));
    chk({tag, ".tx_data1"}, 32'(bus.tx_data1), 32'(d1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.setup_token = 1'b0; bus.in_token = 1'b0; bus.out_token = 1'b0;
    bus.rx_byte_valid = 1'b0; bus.rx_pkt_end = 1'b0; bus.rx_crc_ok = 1'b0; bus.host_ack = 1'b0;
    set_req(1'b0, 2'd0, 8'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) tick();
    chk("rst.tx_len", 32'(bus.tx_len), 32'd0);
    chk("rst.tx_data1", 32'(bus.tx_data1), 32'd0);
    chk("rst.dev_addr", 32'(bus.dev_addr), 32'd0);
    chk("rst.config", 32'(bus.config_value), 32'd0);
    chk("rst.pulses", 32'({bus.sbuf_en, bus.sbuf_clear, bus.tx_req, bus.hs_ack, bus.hs_stall, bus.hs_nak}), 32'd0);
    reset = 1'b1;
    tick();
    in_tok();
    chk("idle.in_nak", 32'(bus.hs_nak), 32'd1);
    out_tok();
    chk("idle.out_nak", 32'(bus.hs_nak), 32'd1);

    // GET_DESCRIPTOR device, wLength 18, single short packet
    set_req(1'b1, 2'd0, 8'd6, 16'h0100, 16'd18, 16'd18);
    setup_pkt(8, 1'b1, ackSeen);
    chk("gd18.setup_ack", 32'(ackSeen), 32'd1);
    chk("gd18.sbuf_en_off", 32'(bus.sbuf_en), 32'd0);
    in_tok();
    chk_tx("gd18.pkt0", 18, 0, 1'b1);
    ack_tok();
    out_tok();
    chk("gd18.out_no_hs", 32'({bus.hs_ack, bus.hs_nak, bus.hs_stall}), 32'd0);
    pkt_end(1'b1);
    chk("gd18.status_ack", 32'(bus.hs_ack), 32'd1);
    in_tok();
    chk("gd18.idle_nak", 32'(bus.hs_nak), 32'd1);

    // wLength 255, desc 128: 64/64/ZLP, with one resend of the first packet
    set_req(1'b1, 2'd0, 8'd6, 16'h0200, 16'd255, 16'd128);
    setup_pkt(8, 1'b1, ackSeen);
    chk("gd128.setup_ack", 32'(ackSeen), 32'd1);
    in_tok();
    chk_tx("gd128.pkt0", 64, 0, 1'b1);
    in_tok();
    chk_tx("gd128.resend", 64, 0, 1'b1);
    ack_tok();
    in_tok();
    chk_tx("gd128.pkt1", 64, 64, 1'b0);
    ack_tok();
    in_tok();
    chk_tx("gd128.zlp", 0, 128, 1'b1);
    ack_tok();
    pkt_end(1'b0);
    chk("gd128.badcrc_noack", 32'(bus.hs_ack), 32'd0);
    in_tok();
    chk("gd128.status_in_stall", 32'(bus.hs_stall), 32'd1);
    pkt_end(1'b1);
    chk("gd128.status_ack", 32'(bus.hs_ack), 32'd1);

    // SET_ADDRESS 0x23: address changes only after the status ACK
    set_req(1'b0, 2'd0, 8'd5, 16'h0023, 16'd0, 16'd0);
    setup_pkt(8, 1'b1, ackSeen);
    chk("addr.setup_ack", 32'(ackSeen), 32'd1);
    in_tok();
    chk_tx("addr.zlp", 0, 128, 1'b1);
    chk("addr.before_ack", 32'(bus.dev_addr), 32'd0);
    bus.host_ack = 1'b1;
    chk("addr.during_ack", 32'(bus.dev_addr), 32'd0);
    tick();
    bus.host_ack = 1'b0;
    chk("addr.after_ack", 32'(bus.dev_addr), 32'h23);
    in_tok();
    chk("addr.idle_nak", 32'(bus.hs_nak), 32'd1);

    // Short and corrupted SETUP packets are ignored
    set_req(1'b1, 2'd0, 8'd6, 16'h0100, 16'd18, 16'd18);
    setup_pkt(7, 1'b1, ackSeen);
    chk("short7.no_ack", 32'(ackSeen), 32'd0);
    in_tok();
    chk("short7.idle_nak", 32'(bus.hs_nak), 32'd1);
    setup_pkt(8, 1'b0, ackSeen);
    chk("badcrc.no_ack", 32'(ackSeen), 32'd0);
    setup_pkt(9, 1'b1, ackSeen);
    chk("long9.no_ack", 32'(ackSeen), 32'd0);

    // New SETUP mid data stage aborts; SET_CONFIGURATION 1 then commits
    setup_pkt(8, 1'b1, ackSeen);
    in_tok();
    chk_tx("abort.pkt0", 18, 0, 1'b1);
    set_req(1'b0, 2'd0, 8'd9, 16'h0001, 16'd0, 16'd0);
    setup_pkt(8, 1'b1, ackSeen);
    chk("cfg.setup_ack", 32'(ackSeen), 32'd1);
    in_tok();
    chk_tx("cfg.zlp", 0, 0, 1'b1);
    ack_tok();
    chk("cfg.value", 32'(bus.config_value), 32'd1);
    chk("cfg.addr_kept", 32'(bus.dev_addr), 32'h23);

    // Vendor request: always STALL until the next SETUP
    set_req(1'b1, 2'd2, 8'd6, 16'h0100, 16'd8, 16'd18);
    setup_pkt(8, 1'b1, ackSeen);
    in_tok();
    chk("vendor.in_stall", 32'(bus.hs_stall), 32'd1);
    out_tok();
    chk("vendor.out_stall", 32'(bus.hs_stall), 32'd1);

    // Unsupported standard no-data request 0x33
    set_req(1'b0, 2'd0, 8'h33, 16'h0045, 16'd0, 16'd0);
    setup_pkt(8, 1'b1, ackSeen);
    chk("unsup.setup_ack", 32'(ackSeen), 32'd1);
    in_tok();
`ifdef USB_EP0_STALL_EN
    chk("unsup.in_stall", 32'(bus.hs_stall), 32'd1);
    chk("unsup.no_tx", 32'(bus.tx_req), 32'd0);
`else
    chk_tx("unsup.zlp", 0, 0, 1'b1);
    chk("unsup.no_stall", 32'(bus.hs_stall), 32'd0);
    ack_tok();
    in_tok();
    chk("unsup.idle_nak", 32'(bus.hs_nak), 32'd1);
`endif
    chk("unsup.addr_kept", 32'(bus.dev_addr), 32'h23);
    chk("unsup.cfg_kept", 32'(bus.config_value), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ep0_control_seq.md
Name: ep0_control_seq

Overview:
- Endpoint-0 control-transfer sequencer for the full-speed device.
- Drives the 8-byte setup buffer: enables it during the SETUP data packet and clears it on each new SETUP. It also decodes the latched request fields.
- Sequences the data and status stages, and supplies the packet layer with IN packet length, offset, data toggle and handshake requests.
- Owns the device address and configuration registers.

Parameters:
MAX_PKT, 64, EP0 max packet size in bytes (8/16/32/64).
LEN_W, 7, width of tx_len; must hold MAX_PKT.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
setup_token  in  1  1-cycle pulse: SETUP token to this device, EP0.
in_token  in  1  1-cycle pulse: IN token to EP0.
out_token  in  1  1-cycle pulse: OUT token to EP0.
rx_byte_valid  in  1  data-packet payload byte strobe.
rx_pkt_end  in  1  1-cycle pulse: data packet finished.
rx_crc_ok  in  1  CRC16 status, valid with rx_pkt_end.
host_ack  in  1  1-cycle pulse: host ACKed our last IN packet.
req_dir, req_type[1:0], req_recipient[4:0], bRequest[7:0], wValue[15:0], wLength[15:0]  in  -  setup-buffer fields.
desc_len  in  16  total length of the descriptor selected by wValue; 0 = none.
sbuf_en  out  1  setup-buffer byte enable.
sbuf_clear  out  1  1-cycle setup-buffer clear.
tx_req  out  1  1-cycle pulse: send IN data packet.
tx_len  out  LEN_W  payload length for tx_req (0..MAX_PKT).
tx_offset  out  16  byte offset of the packet within the descriptor.
tx_data1  out  1  PID for tx_req: 1=DATA1, 0=DATA0.
hs_ack, hs_stall, hs_nak  out  1  1-cycle handshake requests.
dev_addr  out  7  device address.
config_value  out  8  active configuration.

Behaviour:
- Reset (reset=0): state IDLE. All pulses 0; tx_len, tx_offset, tx_data1, dev_addr and config_value are 0.
- setup_token has top priority in every state:
  - sbuf_clear=1 for that cycle; byte count reset; next state SETUP_RX.
  - Any transfer in progress is aborted and pending SET_ADDRESS/SET_CONFIGURATION is discarded.
- IDLE:
  - in_token -> hs_nak.
  - out_token -> hs_nak.
- SETUP_RX:
  - sbuf_en=1; count rx_byte_valid, saturating at 9.
  - On rx_pkt_end with rx_crc_ok and count==8: hs_ack, go DECODE.
  - Otherwise go IDLE with no handshake.
- DECODE: exactly 1 cycle; the buffer fields are stable from this cycle on. Supported requests (req_type=0, req_recipient=0):
  - GET_DESCRIPTOR (6), req_dir=1, desc_len!=0:
    - xfer=min(wLength,desc_len); offset=0; toggle=1.
    - If wLength==0, go STATUS_IN; else go DATA_IN.
  - SET_ADDRESS (5), SET_CONFIGURATION (9): req_dir=0, wLength==0 -> STATUS_IN.
  - Anything else -> STALL.
- DATA_IN:
  - in_token: tx_req, tx_len=min(remaining,MAX_PKT), tx_offset=offset, tx_data1=toggle; go DATA_WAIT.
- DATA_WAIT:
  - host_ack: remaining-=tx_len, offset+=tx_len, toggle^=1.
    - If tx_len<MAX_PKT, or remaining hits 0 with xfer==wLength, go STATUS_OUT.
    - Otherwise go DATA_IN. If remaining is 0 and xfer<wLength, the next IN yields a ZLP.
  - in_token without host_ack: resend the identical packet (same len, offset, toggle).
- out_token in DATA_IN or DATA_WAIT: host ended the data stage early; go STATUS_OUT.
- STATUS_OUT:
  - rx_pkt_end with rx_crc_ok: hs_ack, go IDLE.
  - Bad CRC: stay.
  - in_token: hs_stall.
- STATUS_IN:
  - in_token: tx_req, tx_len=0, tx_data1=1.
  - host_ack: commit, then go IDLE.
    - SET_ADDRESS: dev_addr<=wValue[6:0].
    - SET_CONFIGURATION: config_value<=wValue[7:0].
  - Address changes only after the status ACK, never earlier.
- STALL: every in_token or out_token -> hs_stall; exit only via setup_token.
- At most one of hs_ack/hs_stall/hs_nak per cycle. tx_len, tx_offset and tx_data1 hold their values between tx_req pulses.

Optional Feature:
USB_EP0_STALL_EN:
- Defined: unsupported requests go to STALL as above.
- Undefined: an unsupported request with req_dir=0 and wLength==0 goes to STATUS_IN, completes with a ZLP and has no side effect. All other unsupported requests still STALL.

Test Plan:
- Reset, then SETUP 80 06 00 01 00 00 12 00, desc_len=18 -> hs_ack; IN -> tx_len=18, offset 0, DATA1; host_ack; OUT ZLP -> hs_ack, IDLE.
- GET_DESCRIPTOR wLength=255, desc_len=128, MAX_PKT=64 -> IN packets of 64/64/0 at offsets 0/64/128, toggles 1/0/1; then status OUT.
- SET_ADDRESS wValue=0x0023 -> dev_addr stays 0 through the ZLP tx_req; becomes 0x23 the cycle after host_ack.
- IN repeated without host_ack -> identical tx_len, tx_offset and tx_data1 resent.
- SETUP with only 7 bytes, or bad CRC -> no handshake, IDLE. New setup_token mid DATA_WAIT -> sbuf_clear and restart.
- bRequest=0x33 with req_dir=0, wLength=0 -> with USB_EP0_STALL_EN: IN -> hs_stall; without it: IN -> tx_len=0 DATA1, no state change.
